// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: upstream offer on in_*,
// completed result with flags on out_*.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, out_hi, carry, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, out_hi, carry, zero
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, shift-add multiply
// one multiplier bit per cycle, result held in DONE until consumed.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  state_t           r_state;
  logic [5:0]       r_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_out_hi;
  logic             r_carry;
  logic             r_zero;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last;
  logic [WIDTH:0]   w_alu;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_prod_hi;
  logic [WIDTH-1:0] w_prod_lo;

  // Returns {carry, result} for every single-cycle op.
  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] fa,
                                           input logic [WIDTH-1:0] fb,
                                           input logic [2:0]       fop);
    case (fop)
      OP_ADD:  alu_f = {1'b0, fa} + {1'b0, fb};
      OP_SUB:  alu_f = {1'b0, fa} - {1'b0, fb};
      OP_AND:  alu_f = {1'b0, fa & fb};
      OP_OR:   alu_f = {1'b0, fa | fb};
      OP_NOT:  alu_f = {1'b0, ~fa};
      OP_XOR:  alu_f = {1'b0, fa ^ fb};
      OP_SHL1: alu_f = {fa, 1'b0};
      default: alu_f = '0;
    endcase
  endfunction

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_valid;
  assign bus.out       = r_out;
  assign bus.out_hi    = r_out_hi;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_is_mul = (bus.op == OP_MUL);
  assign w_last   = (r_cnt == 6'(WIDTH - 1));

  always_comb begin
    w_alu = alu_f(bus.a, bus.b, bus.op);
  end

  // One shift-add step: conditionally add multiplicand to the upper half,
  // then shift the whole {acc, multiplier} pair right by one.
  assign w_sum     = r_mplier[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};
  assign w_prod_hi = w_sum[WIDTH:1];
  assign w_prod_lo = {w_sum[0], r_mplier[WIDTH-1:1]};

  // Multiplier datapath: captured at accept, stepped each BUSY cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= bus.a;
      r_mplier <= bus.b;
      r_acc    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_prod_hi;
      r_mplier <= w_prod_lo;
    end
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_out    <= '0;
      r_out_hi <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= BUSY;
              r_cnt   <= '0;
            end else begin
              r_state  <= DONE;
              r_valid  <= 1'b1;
              r_out    <= w_alu[WIDTH-1:0];
              r_out_hi <= '0;
              r_carry  <= w_alu[WIDTH];
              r_zero   <= ~|w_alu[WIDTH-1:0];
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_state  <= DONE;
            r_valid  <= 1'b1;
            r_out    <= w_prod_lo;
            r_out_hi <= w_prod_hi;
            r_carry  <= |w_prod_hi;
            r_zero   <= ~|{w_prod_hi, w_prod_lo};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8: table of hand-computed
// results plus hold, mid-operation reset and back-to-back sequences.
module tb_alu_seq;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;
  int   cyc;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [7:0] eh;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int idx, input string tag);
    chk({tag, "_out"},    32'(bus.out),    32'(tv[idx].eo));
    chk({tag, "_out_hi"}, 32'(bus.out_hi), 32'(tv[idx].eh));
    chk({tag, "_carry"},  32'(bus.carry),  32'(tv[idx].ec));
    chk({tag, "_zero"},   32'(bus.zero),   32'(tv[idx].ez));
  endtask

  task automatic run_vec(input int idx);
    int   lat;
    logic busy_ok;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.a        = tv[idx].a;
    bus.b        = tv[idx].b;
    bus.op       = tv[idx].op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.op       = 3'($urandom);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (tv[idx].op == 3'b111) ? 32'(W + 1) : 32'd1);
    chk({tag, "_busy_no_ready"}, 32'(busy_ok), 32'd1);
    chk({tag, "_done_no_ready"}, 32'(bus.in_ready), 32'd0);
    check_result(idx, tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_consumed"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int   n;
    int   acc_cyc;
    int   prev_acc;
    logic ok;
    int   b2b[8];

    n_pass = 0;
    n_tot  = 0;

    tv[0]  = '{3'd0, 8'h0F, 8'h01, 8'h10, 8'h00, 1'b0, 1'b0};
    tv[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
    tv[2]  = '{3'd1, 8'h05, 8'h06, 8'hFF, 8'h00, 1'b1, 1'b0};
    tv[3]  = '{3'd1, 8'h06, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0};
    tv[4]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0};
    tv[5]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0};
    tv[6]  = '{3'd4, 8'h5A, 8'h33, 8'hA5, 8'h00, 1'b0, 1'b0};
    tv[7]  = '{3'd5, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1};
    tv[8]  = '{3'd6, 8'h81, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0};
    tv[9]  = '{3'd6, 8'h40, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0};
    tv[10] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0};
    tv[11] = '{3'd7, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0};
    tv[12] = '{3'd7, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1};
    tv[13] = '{3'd7, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0};
    tv[14] = '{3'd7, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    tick();
    tick();
    chk("reset_outputs", {20'd0, bus.out_valid, bus.in_ready, bus.carry, bus.zero,
                          bus.out_hi[3:0], bus.out}, 32'd0);
    chk("reset_out_hi", 32'(bus.out_hi), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Result must hold while the downstream stalls and inputs churn.
    bus.a = 8'h81; bus.b = 8'h00; bus.op = 3'd6; bus.in_valid = 1'b1;
    tick();
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
      bus.in_valid = 1'($urandom);
      tick();
      if (bus.out !== 8'h02 || bus.carry !== 1'b1 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.out_hi !== 8'h00) ok = 1'b0;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hold_consumed", {31'd0, bus.out_valid}, 32'd0);
    chk("hold_ready_next", 32'(bus.in_ready), 32'd1);

    // Reset mid-multiply discards the operation; outputs clear at once.
    bus.a = 8'h0F; bus.b = 8'h11; bus.op = 3'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {20'd0, bus.out_valid, bus.in_ready, bus.carry, bus.zero,
                         4'd0, bus.out}, 32'd0);
    chk("rst_mid_busy_hi", 32'(bus.out_hi), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("rst_no_result", 32'(ok), 32'd1);
    run_vec(5);

    // Back-to-back, all eight ops, downstream always ready.
    b2b = '{0, 2, 4, 5, 6, 7, 8, 10};
    bus.out_ready = 1'b1;
    prev_acc = 0;
    for (int k = 0; k < 8; k++) begin
      bus.a        = tv[b2b[k]].a;
      bus.b        = tv[b2b[k]].b;
      bus.op       = tv[b2b[k]].op;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 40) begin
        tick();
        n++;
      end
      chk($sformatf("b2b%0d_ready_wait", k), 32'(n < 40), 32'd1);
      acc_cyc = cyc;
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), 32'(acc_cyc - prev_acc), 32'd2);
      prev_acc = acc_cyc;
      tick();
      n = 0;
      while (!bus.out_valid && n < 40) begin
        tick();
        n++;
      end
      check_result(b2b[k], $sformatf("b2b%0d", k));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal values 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand/op offer from upstream.
REQ-005 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: op  input  3  operation select.
REQ-009 Port: out_valid  output  1  result registers hold a completed result.
REQ-010 Port: out_ready  input  1  downstream consumes the result.
REQ-011 Port: out  output  WIDTH  result, low WIDTH bits.
REQ-012 Port: out_hi  output  WIDTH  high half of MUL product; 0 for all other ops.
REQ-013 Port: carry  output  1  carry/borrow/shift-out/product-overflow flag.
REQ-014 Port: zero  output  1  set when out and out_hi are both 0.

Function
REQ-015 The op encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT a, 101 XOR, 110 SHL1, 111 MUL.
REQ-016 ADD SHALL give {carry,out} = a+b, computed at WIDTH+1 bits.
REQ-017 SUB SHALL give out = a-b mod 2^WIDTH, with carry=1 iff a<b (unsigned borrow).
REQ-018 AND, OR, XOR and NOT SHALL give the bitwise result, with carry=0.
REQ-019 SHL1 SHALL give out = a<<1 with LSB 0, and carry = a[WIDTH-1].
REQ-020 MUL SHALL give the unsigned product {out_hi,out} = a*b, with carry = |out_hi.
REQ-021 MUL SHALL be computed iteratively by shift-add, one multiplier bit per cycle, taking exactly WIDTH BUSY cycles; a combinational multiplier SHALL NOT be used.
REQ-022 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-023 in_ready SHALL be 1 only in IDLE with rst low.
REQ-024 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b and op are captured at that edge.
REQ-025 Non-MUL accept: IDLE->DONE; result and flags registered at the accept edge; out_valid=1 from the next cycle (latency 1).
REQ-026 MUL accept: IDLE->BUSY; after WIDTH BUSY cycles ->DONE; out_valid=1 exactly WIDTH+1 cycles after the accept edge.
REQ-027 While in DONE, out, out_hi, carry and zero SHALL hold stable until consumed.
REQ-028 A result SHALL be consumed on a rising edge in DONE with out_ready=1; state ->IDLE and out_valid->0 on that edge.
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 Operand or op changes while BUSY or DONE SHALL have no effect on the result in flight.
REQ-031 After a consume the block SHALL NOT accept in the same cycle; the next accept is possible one cycle later (max throughput 1 op per 2 cycles).
REQ-032 The zero flag SHALL be computed from the final registered out and out_hi.

Reset
REQ-033 While rst=1: state=IDLE; out=0; out_hi=0; carry=0; zero=0; out_valid=0; in_ready=0.
REQ-034 Reset asserted mid-BUSY or mid-DONE SHALL discard the operation immediately, with no result ever presented.
REQ-035 After rst deasserts, in_ready SHALL be 1 in the first cycle and an accept is legal on the first rising edge.

Verification (WIDTH=8)
REQ-036 Scenario: ADD a=0x0F b=0x01 -> 1 cycle later out_valid=1, out=0x10, carry=0, zero=0.
REQ-037 Scenario: ADD a=0xFF b=0x01 -> out=0x00, carry=1, zero=1; then SUB a=0x05 b=0x06 -> out=0xFF, carry=1.
REQ-038 Scenario: MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept; out=0x01, out_hi=0xFE, carry=1, zero=0; in_ready=0 throughout.
REQ-039 Scenario: SHL1 a=0x81 with out_ready held 0 for 5 cycles while a/b/op toggle -> out=0x02, carry=1 held stable; consumed on the out_ready=1 edge; in_ready=1 on the next cycle.
REQ-040 Scenario: MUL a=0x0F b=0x11 accepted, then rst pulsed 3 cycles later -> all outputs 0 immediately, out_valid never rises; a following OR a=0xF0 b=0x0F -> out=0xFF.
REQ-041 Scenario: all 8 ops run back-to-back with out_ready tied 1 -> each result correct, one accept every 2 cycles for non-MUL ops.
